// File: rtl/gcm_sequencer.sv
// Message-level AES-GCM controller driving a single gctr_block: clear, H, E(K,Y0), then N CTR data blocks.
// Result strobes are registered (one cycle after gctr result); oBlock_ready is state-only, asserted in WAITBLK.
module gcm_sequencer #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic             iOpMode,
    input  logic             iEncdec,
    input  logic             iKeylen,
    input  logic [255:0]     iKey,
    input  logic [95:0]      iIV,
    input  logic [CNT_W-1:0] iNumBlocks,
    input  logic [127:0]     iBlock,
    input  logic             iBlock_valid,
    output logic             oBlock_ready,
    output logic             oGctrRstn,
    output logic             oGctrInit,
    output logic             oGctrHashKey,
    output logic             oGctrY0,
    output logic             oGctrOpMode,
    output logic [255:0]     oGctrKey,
    output logic [95:0]      oGctrIV,
    output logic             oGctrKeylen,
    output logic             oGctrEncdec,
    output logic [127:0]     oGctrBlock,
    output logic             oGctrBlock_valid,
    input  logic [127:0]     iGctrResult,
    input  logic             iGctrResult_valid,
    output logic [127:0]     oH,
    output logic             oH_valid,
    output logic [127:0]     oEkY0,
    output logic             oEkY0_valid,
    output logic [127:0]     oResult,
    output logic             oResult_valid,
    output logic             oBusy,
    output logic             oDone,
    output logic             oErr,
    output logic [CNT_W-1:0] oBlockCnt
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_HKEY,
        S_Y0,
        S_WAITBLK,
        S_DATA,
        S_GAP,
        S_DONE
    } state_t;

    state_t r_state;
    state_t r_next_job;
    state_t w_next;
    state_t w_next_job;

    logic             r_opmode;
    logic             r_encdec;
    logic             r_keylen;
    logic [255:0]     r_key;
    logic [95:0]      r_iv;
    logic [CNT_W-1:0] r_num_blocks;
    logic [127:0]     r_block;
    logic [127:0]     r_h;
    logic             r_h_vld;
    logic [127:0]     r_eky0;
    logic             r_eky0_vld;
    logic [127:0]     r_res;
    logic             r_res_vld;
    logic             r_err;
    logic [CNT_W-1:0] r_blk_cnt;
    logic [TMO_W-1:0] r_tmo_cnt;

    logic             w_job;
    logic             w_tmo_hit;
    logic             w_nz;
    logic             w_more;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_job     = (r_state == S_HKEY) || (r_state == S_Y0) || (r_state == S_DATA);
    assign w_tmo_hit = (TIMEOUT != 0) && (r_tmo_cnt == TMO_LAST);
    assign w_nz      = (r_num_blocks != '0);
    assign w_cnt_inc = r_blk_cnt + CNT_W'(1);
    assign w_more    = (w_cnt_inc < r_num_blocks);

    always_comb begin
        w_next     = r_state;
        w_next_job = r_next_job;
        case (r_state)
            S_IDLE: begin
                if (iStart) w_next = S_CLR;
            end
            S_CLR: begin
                if (!r_opmode)  w_next = S_HKEY;
                else if (w_nz)  w_next = S_WAITBLK;
                else            w_next = S_DONE;
            end
            S_HKEY: begin
                if (iGctrResult_valid) begin
                    w_next     = S_GAP;
                    w_next_job = S_Y0;
                end else if (w_tmo_hit) begin
                    w_next = S_DONE;
                end
            end
            S_Y0: begin
                if (iGctrResult_valid) begin
                    w_next     = S_GAP;
                    w_next_job = w_nz ? S_WAITBLK : S_DONE;
                end else if (w_tmo_hit) begin
                    w_next = S_DONE;
                end
            end
            S_WAITBLK: begin
                if (iBlock_valid) w_next = S_DATA;
            end
            S_DATA: begin
                if (iGctrResult_valid) begin
                    w_next     = S_GAP;
                    w_next_job = w_more ? S_WAITBLK : S_DONE;
                end else if (w_tmo_hit) begin
                    w_next = S_DONE;
                end
            end
            // One idle cycle lets gctr_block see oGctrInit low between jobs.
            S_GAP:   w_next = r_next_job;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state    <= S_IDLE;
            r_next_job <= S_IDLE;
        end else begin
            r_state    <= w_next;
            r_next_job <= w_next_job;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_opmode     <= 1'b0;
            r_encdec     <= 1'b0;
            r_keylen     <= 1'b0;
            r_key        <= '0;
            r_iv         <= '0;
            r_num_blocks <= '0;
            r_block      <= '0;
            r_h          <= '0;
            r_h_vld      <= 1'b0;
            r_eky0       <= '0;
            r_eky0_vld   <= 1'b0;
            r_res        <= '0;
            r_res_vld    <= 1'b0;
            r_err        <= 1'b0;
            r_blk_cnt    <= '0;
            r_tmo_cnt    <= '0;
        end else begin
            r_h_vld    <= 1'b0;
            r_eky0_vld <= 1'b0;
            r_res_vld  <= 1'b0;

            if ((r_state == S_IDLE) && iStart) begin
                r_opmode     <= iOpMode;
                r_encdec     <= iEncdec;
                r_keylen     <= iKeylen;
                r_key        <= iKey;
                r_iv         <= iIV;
                r_num_blocks <= iNumBlocks;
                r_err        <= 1'b0;
                r_blk_cnt    <= '0;
            end

            if ((r_state == S_HKEY) && iGctrResult_valid) begin
                r_h     <= iGctrResult;
                r_h_vld <= 1'b1;
            end
            if ((r_state == S_Y0) && iGctrResult_valid) begin
                r_eky0     <= iGctrResult;
                r_eky0_vld <= 1'b1;
            end
            if ((r_state == S_DATA) && iGctrResult_valid) begin
                r_res     <= iGctrResult;
                r_res_vld <= 1'b1;
                r_blk_cnt <= w_cnt_inc;
            end
            if ((r_state == S_WAITBLK) && iBlock_valid) begin
                r_block <= iBlock;
            end

            if (w_job && !iGctrResult_valid && w_tmo_hit) begin
                r_err <= 1'b1;
            end

            // Counter restarts from zero on every entry into a job state.
            if (w_job && (w_next == r_state)) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            else                              r_tmo_cnt <= '0;
        end
    end

    assign oBlock_ready     = (r_state == S_WAITBLK);
    assign oGctrRstn        = (r_state != S_CLR);
    assign oGctrInit        = w_job;
    assign oGctrHashKey     = (r_state == S_HKEY);
    assign oGctrY0          = (r_state == S_Y0);
    assign oGctrOpMode      = r_opmode;
    assign oGctrKey         = r_key;
    assign oGctrIV          = r_iv;
    assign oGctrKeylen      = r_keylen;
    assign oGctrEncdec      = r_encdec;
    assign oGctrBlock       = r_block;
    assign oGctrBlock_valid = (r_state == S_DATA);
    assign oH               = r_h;
    assign oH_valid         = r_h_vld;
    assign oEkY0            = r_eky0;
    assign oEkY0_valid      = r_eky0_vld;
    assign oResult          = r_res;
    assign oResult_valid    = r_res_vld;
    assign oBusy            = (r_state != S_IDLE);
    assign oDone            = (r_state == S_DONE);
    assign oErr             = r_err;
    assign oBlockCnt        = r_blk_cnt;

endmodule

// File: tb/tb_gcm_sequencer.sv
// Bench for gcm_sequencer: a behavioural gctr stub returns known AES-GCM (K=0, IV=0) values.
module tb_gcm_sequencer;

    localparam int CNT_W    = 16;
    localparam int STUB_LAT = 3;

    localparam logic [127:0] H128   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] EY0128 = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    localparam logic [127:0] Y1128  = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] H256   = 128'hdc95c078a2408989ad48a21492842087;
    localparam logic [127:0] EY0256 = 128'h530f8afbc74536b9a963b4f1c4cb738b;
    localparam logic [127:0] Y1256  = 128'hcea7403d4d606b6e074ec5d3baf39d18;

    logic             iClk = 1'b0;
    logic             iRst = 1'b1;
    logic             iStart = 1'b0;
    logic             iOpMode = 1'b0;
    logic             iEncdec = 1'b0;
    logic             iKeylen = 1'b0;
    logic [255:0]     iKey = '0;
    logic [95:0]      iIV = '0;
    logic [CNT_W-1:0] iNumBlocks = '0;
    logic [127:0]     iBlock = '0;
    logic             iBlock_valid = 1'b0;
    logic [127:0]     iGctrResult = '0;
    logic             iGctrResult_valid = 1'b0;

    logic             oBlock_ready, oGctrRstn, oGctrInit, oGctrHashKey, oGctrY0, oGctrOpMode;
    logic [255:0]     oGctrKey;
    logic [95:0]      oGctrIV;
    logic             oGctrKeylen, oGctrEncdec, oGctrBlock_valid;
    logic [127:0]     oGctrBlock, oH, oEkY0, oResult;
    logic             oH_valid, oEkY0_valid, oResult_valid, oBusy, oDone, oErr;
    logic [CNT_W-1:0] oBlockCnt;

    gcm_sequencer #(.CNT_W(CNT_W), .TIMEOUT(16)) dut (
        .iClk(iClk), .iRst(iRst), .iStart(iStart), .iOpMode(iOpMode), .iEncdec(iEncdec),
        .iKeylen(iKeylen), .iKey(iKey), .iIV(iIV), .iNumBlocks(iNumBlocks),
        .iBlock(iBlock), .iBlock_valid(iBlock_valid), .oBlock_ready(oBlock_ready),
        .oGctrRstn(oGctrRstn), .oGctrInit(oGctrInit), .oGctrHashKey(oGctrHashKey),
        .oGctrY0(oGctrY0), .oGctrOpMode(oGctrOpMode), .oGctrKey(oGctrKey), .oGctrIV(oGctrIV),
        .oGctrKeylen(oGctrKeylen), .oGctrEncdec(oGctrEncdec), .oGctrBlock(oGctrBlock),
        .oGctrBlock_valid(oGctrBlock_valid), .iGctrResult(iGctrResult),
        .iGctrResult_valid(iGctrResult_valid), .oH(oH), .oH_valid(oH_valid), .oEkY0(oEkY0),
        .oEkY0_valid(oEkY0_valid), .oResult(oResult), .oResult_valid(oResult_valid),
        .oBusy(oBusy), .oDone(oDone), .oErr(oErr), .oBlockCnt(oBlockCnt)
    );

    always #5 iClk = ~iClk;

    // gctr stub: answers each job STUB_LAT cycles after oGctrInit rises, unless stub_dead.
    logic stub_dead = 1'b0;
    int   stub_cnt  = 0;

    function automatic logic [127:0] stub_result();
        logic [127:0] ks;
        if (oGctrKeylen) ks = oGctrHashKey ? H256 : (oGctrY0 ? EY0256 : Y1256);
        else             ks = oGctrHashKey ? H128 : (oGctrY0 ? EY0128 : Y1128);
        return (oGctrHashKey || oGctrY0) ? ks : (ks ^ oGctrBlock);
    endfunction

    always @(negedge iClk) begin
        if (iRst || !oGctrInit) begin
            stub_cnt = 0;
            iGctrResult_valid = 1'b0;
        end else begin
            stub_cnt++;
            iGctrResult_valid = 1'b0;
            if (!stub_dead && stub_cnt == STUB_LAT) begin
                iGctrResult_valid = 1'b1;
                iGctrResult = stub_result();
            end
        end
    end

    int n_h = 0, n_ey0 = 0, n_res = 0, n_done = 0, n_flag = 0;
    int cyc = 0, cyc_ey0 = 0, cyc_done = 0, cyc_init = 0;
    logic init_prev = 1'b0;
    logic [127:0] last_h = '0, last_ey0 = '0;
    logic [127:0] res_q[$];

    always @(posedge iClk) begin
        #1;
        cyc++;
        if (oH_valid) begin n_h++; last_h = oH; end
        if (oEkY0_valid) begin n_ey0++; last_ey0 = oEkY0; cyc_ey0 = cyc; end
        if (oResult_valid) begin n_res++; res_q.push_back(oResult); end
        if (oDone) begin n_done++; cyc_done = cyc; end
        if (oGctrInit && !init_prev) cyc_init = cyc;
        init_prev = oGctrInit;
        if (oGctrHashKey || oGctrY0) n_flag++;
    end

    int n_cmp = 0, n_bad = 0;
    int b_h, b_ey0, b_res, b_done, b_flag;
    logic err_after_start;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_msg(input logic op, input logic kl, input int nblk,
                           input logic [127:0] base, input int g0, input int g1, input int g2);
        int guard;
        int gap;
        repeat (2) @(negedge iClk);
        b_h = n_h; b_ey0 = n_ey0; b_res = n_res; b_done = n_done; b_flag = n_flag;
        iOpMode = op; iKeylen = kl; iNumBlocks = CNT_W'(nblk);
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        err_after_start = oErr;
        for (int i = 0; i < nblk; i++) begin
            gap = (i == 0) ? g0 : ((i == 1) ? g1 : g2);
            repeat (gap) @(negedge iClk);
            iBlock = base + 128'(i);
            iBlock_valid = 1'b1;
            guard = 0;
            while (!oBlock_ready && guard < 300) begin
                @(negedge iClk);
                guard++;
            end
            if (guard >= 300) chk("blk_ready_wait", 1'b0, 1'b1);
            @(negedge iClk);
            iBlock_valid = 1'b0;
        end
        guard = 0;
        while (n_done == b_done && guard < 400) begin
            @(negedge iClk);
            guard++;
        end
        if (guard >= 400) chk("done_wait", 1'b0, 1'b1);
        @(negedge iClk);
    endtask

    typedef struct {
        string        name;
        logic         op;
        logic         kl;
        int           nblk;
        int           exp_nh;
        int           exp_ney0;
        int           exp_nres;
        logic [127:0] exp_h;
        logic [127:0] exp_ey0;
        logic [127:0] exp_res;
    } vec_t;

    task automatic run_vec(input vec_t v);
        run_msg(v.op, v.kl, v.nblk, '0, 0, 0, 0);
        chk({v.name, "_nh"},   128'(n_h - b_h),       128'(v.exp_nh));
        chk({v.name, "_ney0"}, 128'(n_ey0 - b_ey0),   128'(v.exp_ney0));
        chk({v.name, "_nres"}, 128'(n_res - b_res),   128'(v.exp_nres));
        chk({v.name, "_ndone"}, 128'(n_done - b_done), 128'd1);
        if (v.exp_nh > 0)   chk({v.name, "_H"},   last_h,     v.exp_h);
        if (v.exp_ney0 > 0) chk({v.name, "_EY0"}, last_ey0,   v.exp_ey0);
        if (v.exp_nres > 0) chk({v.name, "_res"}, res_q[b_res], v.exp_res);
        chk({v.name, "_cnt"},  128'(oBlockCnt), 128'(v.nblk));
        chk({v.name, "_busy"}, 128'(oBusy), 128'd0);
        chk({v.name, "_err"},  128'(oErr), 128'd0);
    endtask

    vec_t vecs[4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"gcm128_n1", 1'b0, 1'b0, 1, 1, 1, 1, H128, EY0128, Y1128};
        vecs[1] = '{"gcm128_n0", 1'b0, 1'b0, 0, 1, 1, 0, H128, EY0128, '0};
        vecs[2] = '{"gcm256_n1", 1'b0, 1'b1, 1, 1, 1, 1, H256, EY0256, Y1256};
        vecs[3] = '{"aes128_n1", 1'b1, 1'b0, 1, 0, 0, 1, '0, '0, Y1128};

        repeat (3) @(negedge iClk);
        chk("rst_rstn",  128'(oGctrRstn), 128'd1);
        chk("rst_busy",  128'(oBusy), 128'd0);
        chk("rst_ready", 128'(oBlock_ready), 128'd0);
        chk("rst_init",  128'(oGctrInit), 128'd0);
        chk("rst_cnt",   128'(oBlockCnt), 128'd0);
        chk("rst_res",   oResult, 128'd0);
        iRst = 1'b0;

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // NumBlocks=0: done follows the E(K,Y0) strobe through the single gap cycle
        run_vec(vecs[1]);
        chk("n0_done_after_ey0_ok", 128'((cyc_done - cyc_ey0) >= 1 && (cyc_done - cyc_ey0) <= 2), 128'd1);

        // AES-only, three blocks with increasing valid gaps
        run_msg(1'b1, 1'b0, 3, 128'h1111_0000_0000_0000_0000_0000_0000_0000, 0, 5, 17);
        chk("aes3_nres", 128'(n_res - b_res), 128'd3);
        chk("aes3_nh",   128'(n_h - b_h), 128'd0);
        chk("aes3_ney0", 128'(n_ey0 - b_ey0), 128'd0);
        chk("aes3_flags", 128'(n_flag - b_flag), 128'd0);
        for (int i = 0; i < 3; i++)
            chk($sformatf("aes3_res%0d", i), res_q[b_res + i],
                Y1128 ^ (128'h1111_0000_0000_0000_0000_0000_0000_0000 + 128'(i)));
        chk("aes3_cnt", 128'(oBlockCnt), 128'd3);

        // Timeout: stub never answers the hash-key job
        stub_dead = 1'b1;
        run_msg(1'b0, 1'b0, 0, '0, 0, 0, 0);
        chk("tmo_err",  128'(oErr), 128'd1);
        chk("tmo_nh",   128'(n_h - b_h), 128'd0);
        chk("tmo_done", 128'(n_done - b_done), 128'd1);
        chk("tmo_lat_ok", 128'((cyc_done - cyc_init) >= 16 && (cyc_done - cyc_init) <= 18), 128'd1);
        stub_dead = 1'b0;
        run_vec(vecs[0]);
        chk("tmo_err_cleared_on_start", 128'(err_after_start), 128'd0);

        // Start while busy is ignored; async reset mid-DATA aborts without oDone
        repeat (2) @(negedge iClk);
        b_done = n_done;
        iOpMode = 1'b0; iKeylen = 1'b0; iNumBlocks = CNT_W'(2);
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        chk("bsy_busy", 128'(oBusy), 128'd1);
        iBlock = 128'hABCD;
        iBlock_valid = 1'b1;
        for (int g = 0; g < 200 && !oGctrBlock_valid; g++) @(negedge iClk);
        chk("bsy_in_data", 128'(oGctrBlock_valid), 128'd1);
        iBlock_valid = 1'b0;
        iKeylen = 1'b1;
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        chk("bsy_keylen_held", 128'(oGctrKeylen), 128'd0);
        chk("bsy_blk_latched", oGctrBlock, 128'hABCD);
        iRst = 1'b1;
        #1;
        chk("arst_busy",  128'(oBusy), 128'd0);
        chk("arst_init",  128'(oGctrInit), 128'd0);
        chk("arst_rstn",  128'(oGctrRstn), 128'd1);
        chk("arst_blk",   oGctrBlock, 128'd0);
        chk("arst_h",     oH, 128'd0);
        chk("arst_bvld",  128'(oGctrBlock_valid), 128'd0);
        @(negedge iClk);
        chk("arst_nodone", 128'(n_done - b_done), 128'd0);
        iRst = 1'b0;
        iKeylen = 1'b0;
        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
